// File: rtl/st_buf.sv
// Store buffer: allocates at dispatch, captures addr/data at execute, commits in order, drains committed entries to dcache.
// Latency: retire at edge k makes the entry drainable in cycle k+1; dispatch_id advances the cycle after a fire.
// Backpressure: dispatch_ready drops when full or flushing; dcache outputs hold steady while dcache_st_ready is low.
module st_buf #(
  parameter int N_ENTRIES = 8,
  parameter int ID_WIDTH  = $clog2(N_ENTRIES)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                dispatch_ready,
  input  logic                dispatch_valid,
  output logic [ID_WIDTH-1:0] dispatch_id,
  input  logic                exec_wr_valid,
  input  logic [ID_WIDTH-1:0] exec_wr_id,
  input  logic [31:0]         exec_wr_eff_addr,
  input  logic [31:0]         exec_wr_st_data,
  input  logic [1:0]          exec_wr_st_width,
  input  logic                retire_valid,
  input  logic                flush,
  output logic                dcache_st_valid,
  input  logic                dcache_st_ready,
  output logic [31:0]         dcache_st_addr,
  output logic [31:0]         dcache_st_data,
  output logic [1:0]          dcache_st_width,
  output logic [ID_WIDTH:0]   count,
  output logic                empty
);

  localparam logic [ID_WIDTH:0] PTR_ONE = {{ID_WIDTH{1'b0}}, 1'b1};
  localparam logic [ID_WIDTH:0] DEPTH   = N_ENTRIES[ID_WIDTH:0];

  // Pointers carry a wrap bit so full and empty are distinguishable.
  logic [ID_WIDTH:0]    head_q, head_d;
  logic [ID_WIDTH:0]    cmt_q, cmt_d;
  logic [ID_WIDTH:0]    tail_q, tail_d;
  logic [N_ENTRIES-1:0] written_q, written_d;

  logic [31:0] addr_q  [N_ENTRIES];
  logic [31:0] data_q  [N_ENTRIES];
  logic [1:0]  width_q [N_ENTRIES];

  logic [ID_WIDTH-1:0] head_idx, cmt_idx, tail_idx;
  logic [ID_WIDTH:0]   wr_off, uncmt_cnt;
  logic                full, dispatch_fire, retire_fire, drain_fire;
  logic                wr_in_range, wr_en;

  assign head_idx = head_q[ID_WIDTH-1:0];
  assign cmt_idx  = cmt_q[ID_WIDTH-1:0];
  assign tail_idx = tail_q[ID_WIDTH-1:0];

  assign count = tail_q - head_q;
  assign empty = (count == '0);
  assign full  = (count == DEPTH);

  assign dispatch_ready = !full && !flush;
  assign dispatch_id    = tail_idx;
  assign dispatch_fire  = dispatch_valid && dispatch_ready;

  assign retire_fire = retire_valid && (cmt_q != tail_q);

  assign dcache_st_valid = (head_q != cmt_q);
  assign drain_fire      = dcache_st_valid && dcache_st_ready;
  // Fields are zeroed when nothing is drainable so idle/reset outputs are clean.
  assign dcache_st_addr  = dcache_st_valid ? addr_q[head_idx]  : '0;
  assign dcache_st_data  = dcache_st_valid ? data_q[head_idx]  : '0;
  assign dcache_st_width = dcache_st_valid ? width_q[head_idx] : '0;

  // Distance of the write id past cmt, modulo the ring, compared to the uncommitted span.
  assign wr_off      = {1'b0, exec_wr_id - cmt_idx};
  assign uncmt_cnt   = tail_q - cmt_q;
  assign wr_in_range = (wr_off < uncmt_cnt);
  // During a flush only the entry being committed this very cycle may still be written.
  assign wr_en = exec_wr_valid && wr_in_range &&
                 (!flush || (retire_fire && (exec_wr_id == cmt_idx)));

  // Next-state for pointers and per-entry written flags.
  always_comb begin
    head_d    = head_q;
    cmt_d     = cmt_q;
    tail_d    = tail_q;
    written_d = written_q;
    if (drain_fire)    head_d = head_q + PTR_ONE;
    if (retire_fire)   cmt_d  = cmt_q + PTR_ONE;
    if (dispatch_fire) begin
      tail_d              = tail_q + PTR_ONE;
      written_d[tail_idx] = 1'b0;
    end
    // Flush discards everything younger than the (post-retire) commit point.
    if (flush)         tail_d = cmt_d;
    if (wr_en)         written_d[exec_wr_id] = 1'b1;
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      cmt_q     <= '0;
      tail_q    <= '0;
      written_q <= '0;
    end else begin
      head_q    <= head_d;
      cmt_q     <= cmt_d;
      tail_q    <= tail_d;
      written_q <= written_d;
    end
  end

  // Entry payload capture on an accepted execute write; payload needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      addr_q[exec_wr_id]  <= exec_wr_eff_addr;
      data_q[exec_wr_id]  <= exec_wr_st_data;
      width_q[exec_wr_id] <= exec_wr_st_width;
    end
  end

  // The ROB must never retire a store that has not executed (a same-cycle write counts).
  a_retire_written : assert property (@(posedge clk) disable iff (rst)
      retire_fire |-> (written_q[cmt_idx] || (wr_en && (exec_wr_id == cmt_idx))))
    else $error("st_buf: retire of unwritten entry %0d", cmt_idx);

endmodule

// File: tb/tb_st_buf.sv
module tb_st_buf;
  localparam int N  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          dispatch_ready, dispatch_valid;
  logic [IW-1:0] dispatch_id;
  logic          exec_wr_valid;
  logic [IW-1:0] exec_wr_id;
  logic [31:0]   exec_wr_eff_addr, exec_wr_st_data;
  logic [1:0]    exec_wr_st_width;
  logic          retire_valid, flush;
  logic          dcache_st_valid, dcache_st_ready;
  logic [31:0]   dcache_st_addr, dcache_st_data;
  logic [1:0]    dcache_st_width;
  logic [IW:0]   count;
  logic          empty;

  always #5 clk = ~clk;

  st_buf #(.N_ENTRIES(N), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .dispatch_ready(dispatch_ready), .dispatch_valid(dispatch_valid), .dispatch_id(dispatch_id),
    .exec_wr_valid(exec_wr_valid), .exec_wr_id(exec_wr_id), .exec_wr_eff_addr(exec_wr_eff_addr),
    .exec_wr_st_data(exec_wr_st_data), .exec_wr_st_width(exec_wr_st_width),
    .retire_valid(retire_valid), .flush(flush),
    .dcache_st_valid(dcache_st_valid), .dcache_st_ready(dcache_st_ready),
    .dcache_st_addr(dcache_st_addr), .dcache_st_data(dcache_st_data), .dcache_st_width(dcache_st_width),
    .count(count), .empty(empty)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: program-ordered queue of live stores, oldest first; the first m_ncmt are committed.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  width;
  } ent_t;

  ent_t mq[$];
  ent_t m_e;
  int   m_ncmt = 0;
  int   m_head_id = 0;
  bit   m_live = 0;
  int   m_sz, m_wi;
  bit   m_disp, m_ret, m_drn;
  logic [31:0] drained[$];

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_ncmt    = 0;
      m_head_id = 0;
      m_live    = 1;
    end else if (m_live) begin
      m_sz   = mq.size();
      m_disp = dispatch_valid && (m_sz < N) && !flush;
      m_ret  = retire_valid && (m_sz > m_ncmt);
      m_drn  = (m_ncmt > 0) && dcache_st_ready;
      m_wi   = (int'(exec_wr_id) - m_head_id + N) % N;
      if (exec_wr_valid && m_wi >= m_ncmt && m_wi < m_sz &&
          (!flush || (m_ret && m_wi == m_ncmt))) begin
        m_e.addr  = exec_wr_eff_addr;
        m_e.data  = exec_wr_st_data;
        m_e.width = exec_wr_st_width;
        mq[m_wi]  = m_e;
      end
      if (m_ret) m_ncmt++;
      if (flush) while (mq.size() > m_ncmt) void'(mq.pop_back());
      if (m_disp) begin
        m_e.addr = '0; m_e.data = '0; m_e.width = '0;
        mq.push_back(m_e);
      end
      if (m_drn) begin
        void'(mq.pop_front());
        m_ncmt--;
        m_head_id = (m_head_id + 1) % N;
      end
    end
  end

  // Compare every cycle against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      check("mdl_ready", dispatch_ready, (mq.size() < N) && !flush);
      check("mdl_id", dispatch_id, (m_head_id + mq.size()) % N);
      check("mdl_count", count, mq.size());
      check("mdl_empty", empty, mq.size() == 0);
      check("mdl_valid", dcache_st_valid, m_ncmt > 0);
      if (m_ncmt > 0) begin
        check("mdl_addr", dcache_st_addr, mq[0].addr);
        check("mdl_data", dcache_st_data, mq[0].data);
        check("mdl_width", dcache_st_width, mq[0].width);
      end else begin
        check("mdl_addr0", dcache_st_addr, 0);
      end
    end
  end

  // Record every dcache write actually performed.
  always @(negedge clk) begin
    if (!rst && dcache_st_valid && dcache_st_ready) drained.push_back(dcache_st_addr);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dispatch_valid = 0; exec_wr_valid = 0; retire_valid = 0; flush = 0; dcache_st_ready = 0;
    exec_wr_id = '0; exec_wr_eff_addr = '0; exec_wr_st_data = '0; exec_wr_st_width = '0;
  endtask

  task automatic ex(input int id, input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
    exec_wr_valid = 1; exec_wr_id = IW'(id); exec_wr_eff_addr = a; exec_wr_st_data = d; exec_wr_st_width = w;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    drained.delete();
  endtask

  int n_disp, n_wr, n_ret, guard;

  initial begin
    idle();
    rst = 1;

    // Reset values, then three stores executed out of order and drained in program order.
    do_reset();
    @(negedge clk);
    check("rst_ready", dispatch_ready, 1);
    check("rst_id", dispatch_id, 0);
    check("rst_valid", dcache_st_valid, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      dispatch_valid = 1;
      @(negedge clk);
      check("s1_id", dispatch_id, i);
      tick();
    end
    dispatch_valid = 0;
    @(negedge clk);
    check("s1_count", count, 3);
    tick();
    ex(2, 32'h100, 32'hA2, 2'b10); tick();
    ex(0, 32'h200, 32'hA0, 2'b10); tick();
    ex(1, 32'h300, 32'hA1, 2'b10); tick();
    idle();
    retire_valid = 1; dcache_st_ready = 1;
    repeat (3) tick();
    retire_valid = 0;
    repeat (3) tick();
    @(negedge clk);
    check("s1_ndrain", drained.size(), 3);
    check("s1_drain0", drained[0], 32'h200);
    check("s1_drain1", drained[1], 32'h300);
    check("s1_drain2", drained[2], 32'h100);
    check("s1_empty", empty, 1);
    tick();

    // Fill all entries, full blocks a same-cycle dispatch, then stream 20 stores with wrap.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      dispatch_valid = 1;
      if (i > 0) ex(i - 1, 32'h1000 + 4 * (i - 1), i - 1, 2'b10);
      @(negedge clk);
      check("s2_fill_id", dispatch_id, i);
      tick();
    end
    dispatch_valid = 0;
    ex(7, 32'h1000 + 28, 7, 2'b10);
    @(negedge clk);
    check("s2_full_ready", dispatch_ready, 0);
    check("s2_full_count", count, 8);
    tick();
    idle();
    retire_valid = 1; tick();
    idle();
    dispatch_valid = 1; dcache_st_ready = 1;
    @(negedge clk);
    check("s2_full_blocked", dispatch_ready, 0);
    check("s2_drain_vld", dcache_st_valid, 1);
    tick();
    @(negedge clk);
    check("s2_freed_ready", dispatch_ready, 1);
    check("s2_freed_id", dispatch_id, 0);
    tick();
    n_disp = 9; n_wr = 8; n_ret = 1; guard = 0;
    while ((n_ret < 20 || !empty) && guard < 200) begin
      idle();
      dcache_st_ready = 1;
      retire_valid = (n_ret < n_wr);
      if (n_wr < n_disp) ex(n_wr % 8, 32'h1000 + 4 * n_wr, n_wr, 2'b10);
      dispatch_valid = (n_disp < 20);
      @(negedge clk);
      if (dispatch_valid && dispatch_ready) begin
        check("s2_wrap_id", dispatch_id, n_disp % 8);
        n_disp++;
      end
      if (retire_valid) n_ret++;
      if (exec_wr_valid) n_wr++;
      tick();
      guard++;
    end
    idle();
    check("s2_in_budget", guard < 200, 1);
    check("s2_ndrain", drained.size(), 20);
    for (int k = 0; k < 20; k++) check("s2_order", drained[k], 32'h1000 + 4 * k);

    // Flush with two committed of five; late write past tail is ignored.
    do_reset();
    dispatch_valid = 1; repeat (5) tick(); idle();
    for (int i = 0; i < 5; i++) begin
      ex(i, 32'h2000 + 4 * i, 32'hB0 + i, 2'b01);
      tick();
    end
    idle();
    retire_valid = 1; repeat (2) tick(); idle();
    flush = 1;
    @(negedge clk);
    check("s3_flush_ready", dispatch_ready, 0);
    tick();
    idle();
    @(negedge clk);
    check("s3_count", count, 2);
    check("s3_id", dispatch_id, 2);
    tick();
    ex(4, 32'h9999, 32'h9999, 2'b10); tick(); idle();
    dispatch_valid = 1;
    @(negedge clk);
    check("s3_redisp_id", dispatch_id, 2);
    tick();
    idle();
    @(negedge clk);
    check("s3_written2", dut.written_q[2], 0);
    dcache_st_ready = 1;
    repeat (4) tick();
    idle();
    @(negedge clk);
    check("s3_ndrain", drained.size(), 2);
    check("s3_drain0", drained[0], 32'h2000);
    check("s3_drain1", drained[1], 32'h2004);
    check("s3_count_after", count, 1);

    // Flush together with retire of entry 1, whose execute write lands in the same cycle.
    do_reset();
    dispatch_valid = 1; repeat (4) tick(); idle();
    ex(0, 32'h3000, 32'hC0, 2'b00); tick();
    ex(2, 32'h3008, 32'hC2, 2'b00); tick();
    ex(3, 32'h300C, 32'hC3, 2'b00); tick();
    idle();
    retire_valid = 1; tick();
    retire_valid = 1; flush = 1; dispatch_valid = 1;
    ex(1, 32'h3004, 32'hC1, 2'b00);
    @(negedge clk);
    check("s4_disp_rejected", dispatch_ready, 0);
    tick();
    idle();
    @(negedge clk);
    check("s4_count", count, 2);
    check("s4_id", dispatch_id, 2);
    check("s4_head_addr", dcache_st_addr, 32'h3000);
    dcache_st_ready = 1;
    repeat (3) tick();
    idle();
    @(negedge clk);
    check("s4_ndrain", drained.size(), 2);
    check("s4_drain1", drained[1], 32'h3004);
    check("s4_empty", empty, 1);

    // Stall at the dcache: outputs hold, exactly one write when ready rises.
    do_reset();
    dispatch_valid = 1; tick(); idle();
    ex(0, 32'h40, 32'hDEADBEEF, 2'b10); tick(); idle();
    retire_valid = 1; tick(); idle();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("s5_hold_vld", dcache_st_valid, 1);
      check("s5_hold_addr", dcache_st_addr, 32'h40);
      check("s5_hold_data", dcache_st_data, 32'hDEADBEEF);
      check("s5_hold_width", dcache_st_width, 2'b10);
      tick();
    end
    dcache_st_ready = 1; tick();
    dcache_st_ready = 1; tick();
    idle();
    @(negedge clk);
    check("s5_ndrain", drained.size(), 1);
    check("s5_empty", empty, 1);

    // Reset in the middle of draining three committed stores.
    do_reset();
    dispatch_valid = 1; repeat (3) tick(); idle();
    for (int i = 0; i < 3; i++) begin
      ex(i, 32'h5000 + 4 * i, i, 2'b10);
      tick();
    end
    idle();
    retire_valid = 1; repeat (3) tick(); idle();
    @(negedge clk);
    check("s6_pre_count", count, 3);
    rst = 1; dcache_st_ready = 1;
    tick();
    rst = 0;
    @(negedge clk);
    check("s6_valid", dcache_st_valid, 0);
    check("s6_count", count, 0);
    check("s6_id", dispatch_id, 0);
    repeat (3) tick();
    idle();
    check("s6_no_writes", drained.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
